// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse level sequencer.
// State encoding and one-hot rate select builder.
package pulse_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam int unsigned OH_W = 32;

   // Wide one-hot; callers truncate to their select width.
   function automatic logic [OH_W-1:0] onehot_lvl(
      input int unsigned idx
   );
      return OH_W'(1) << idx;
   endfunction

endpackage

// File: rtl/pulse_edge_cnt.sv
// CP rising-edge detector feeding a terminal counter.
// tc strobes on the edge that completes a level; count then restarts.
module pulse_edge_cnt #(
   parameter int unsigned PPL = 16,
   parameter int unsigned CW  =
      ($clog2(PPL + 1) > 8) ? 8 : $clog2(PPL + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic cp,
   input  logic en,
   input  logic clr,
   output logic tc
);

   logic          cp_q;
   logic [CW-1:0] cnt;
   logic          rise;
   logic          last;

   assign rise = cp & ~cp_q;
   assign last = (cnt == CW'(PPL - 1));
   assign tc   = en & rise & last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cp_q <= 1'b0;
         cnt  <= '0;
      end else begin
         cp_q <= cp;
         if (clr) begin
            cnt <= '0;
         end else if (en && rise) begin
            cnt <= last ? '0 : cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pulse_level_sched.sv
// Steps the generator's one-hot rate select through speed levels,
// advancing after a fixed number of CP edges per level.
module pulse_level_sched
   import pulse_sched_pkg::*;
#(
   parameter int unsigned NUM_LEVELS       = 5,
   parameter int unsigned PULSES_PER_LEVEL = 16,
   parameter int unsigned LVL_W            = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic                  PAUSE,
   input  logic                  MANUAL_EN,
   input  logic [NUM_LEVELS-1:0] MANUAL_SW,
   input  logic                  CP,
   output logic [NUM_LEVELS-1:0] SW,
   output logic [LVL_W-1:0]      LEVEL,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  LEVEL_UP
);

   state_t                state, state_n;
   logic [NUM_LEVELS-1:0] sw_q, sw_n;
   logic [LVL_W-1:0]      lvl_n;
   logic                  up_n;
   logic                  cnt_en;
   logic                  tc;

   assign cnt_en = (state == RUN) & ~PAUSE;

   pulse_edge_cnt #(
      .PPL (PULSES_PER_LEVEL)
   ) u_cnt (
      .clk (CLK),
      .rst (RST),
      .cp  (CP),
      .en  (cnt_en),
      .clr (START),
      .tc  (tc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         sw_q     <= '0;
         LEVEL    <= '0;
         LEVEL_UP <= 1'b0;
      end else begin
         state    <= state_n;
         sw_q     <= sw_n;
         LEVEL    <= lvl_n;
         LEVEL_UP <= up_n;
      end
   end

   always_comb begin
      state_n = state;
      sw_n    = sw_q;
      lvl_n   = LEVEL;
      up_n    = 1'b0;
      if (START) begin
         state_n = RUN;
         lvl_n   = '0;
         sw_n    = NUM_LEVELS'(onehot_lvl(0));
      end else begin
         unique case (state)
            IDLE: begin
               sw_n = '0;
            end
            RUN: begin
               // Pause wins; a coincident edge is dropped by cnt_en.
               if (PAUSE) begin
                  state_n = PAUSED;
                  sw_n    = '0;
               end else if (tc) begin
                  if (LEVEL < LVL_W'(NUM_LEVELS - 1)) begin
                     lvl_n = LEVEL + 1'b1;
                     sw_n  = NUM_LEVELS'(
                        onehot_lvl(32'(LEVEL) + 32'd1));
                     up_n  = 1'b1;
                  end else begin
                     state_n = FINISH;
                     sw_n    = '0;
                  end
               end
            end
            PAUSED: begin
               sw_n = '0;
               if (!PAUSE) begin
                  state_n = RUN;
                  sw_n    = NUM_LEVELS'(onehot_lvl(32'(LEVEL)));
               end
            end
            FINISH: begin
               sw_n = '0;
            end
            default: begin
               state_n = IDLE;
               sw_n    = '0;
            end
         endcase
      end
   end

   assign SW   = MANUAL_EN ? MANUAL_SW : sw_q;
   assign BUSY = (state == RUN) | (state == PAUSED);
   assign DONE = (state == FINISH);

endmodule

// File: tb/tb_pulse_level_sched.sv
// Scoreboard bench for pulse_level_sched with default parameters.
// Stimulus queues expectations; a negedge monitor compares them.
module tb_pulse_level_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       PAUSE = 1'b0;
  logic       MANUAL_EN = 1'b0;
  logic [4:0] MANUAL_SW = 5'b0;
  logic       CP = 1'b0;
  logic [4:0] SW;
  logic [2:0] LEVEL;
  logic       BUSY;
  logic       DONE;
  logic       LEVEL_UP;

  pulse_level_sched dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .PAUSE     (PAUSE),
    .MANUAL_EN (MANUAL_EN),
    .MANUAL_SW (MANUAL_SW),
    .CP        (CP),
    .SW        (SW),
    .LEVEL     (LEVEL),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .LEVEL_UP  (LEVEL_UP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [4:0] sw;
    logic [2:0] lvl;
    logic       busy;
    logic       done;
    logic       up;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if ({SW, LEVEL, BUSY, DONE, LEVEL_UP} !==
          {e.sw, e.lvl, e.busy, e.done, e.up}) begin
        fails++;
        $display("FAIL %s: got sw=%b lvl=%0d busy=%b done=%b up=%b, want sw=%b lvl=%0d busy=%b done=%b up=%b",
                 e.name, SW, LEVEL, BUSY, DONE, LEVEL_UP,
                 e.sw, e.lvl, e.busy, e.done, e.up);
      end
    end
  end

  task automatic chk(input string name, input logic [4:0] sw,
                     input logic [2:0] lvl, input logic busy,
                     input logic done, input logic up);
    exp_t x;
    x.name = name;
    x.sw   = sw;
    x.lvl  = lvl;
    x.busy = busy;
    x.done = done;
    x.up   = up;
    sb.push_back(x);
    @(negedge CLK);
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic edge1();
    CP = 1'b1;
    tick();
    CP = 1'b0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      edge1();
      repeat (7) tick();
    end
  endtask

  task automatic start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("reset", 5'b00000, 3'd0, 0, 0, 0);
    RST = 1'b0;
    tick();
    chk("idle", 5'b00000, 3'd0, 0, 0, 0);

    start();
    tests++;
    if (SW !== 5'b00001) begin
      fails++;
      $display("FAIL start_direct: got sw=%b, want sw=00001", SW);
    end
    chk("start", 5'b00001, 3'd0, 1, 0, 0);
    pulses(15);
    chk("lvl0_15", 5'b00001, 3'd0, 1, 0, 0);
    edge1();
    chk("lvl1_up", 5'b00010, 3'd1, 1, 0, 1);
    tick();
    chk("lvl1_up_off", 5'b00010, 3'd1, 1, 0, 0);

    tick();
    MANUAL_EN = 1'b1;
    MANUAL_SW = 5'b01000;
    #1;
    tests++;
    if (SW !== 5'b01000) begin
      fails++;
      $display("FAIL manual_direct: got sw=%b, want sw=01000", SW);
    end
    chk("manual_on", 5'b01000, 3'd1, 1, 0, 0);
    repeat (4) tick();
    pulses(15);
    edge1();
    chk("manual_cnt", 5'b01000, 3'd2, 1, 0, 1);
    tick();
    MANUAL_EN = 1'b0;
    chk("manual_off", 5'b00100, 3'd2, 1, 0, 0);
    repeat (5) tick();

    pulses(7);
    PAUSE = 1'b1;
    tick();
    chk("pause", 5'b00000, 3'd2, 1, 0, 0);
    pulses(11);
    repeat (11) tick();
    tests++;
    if (BUSY !== 1'b1 || SW !== 5'b00000) begin
      fails++;
      $display("FAIL pause_direct: got busy=%b sw=%b, want busy=1 sw=00000",
               BUSY, SW);
    end
    chk("pause_hold", 5'b00000, 3'd2, 1, 0, 0);
    PAUSE = 1'b0;
    tick();
    chk("resume", 5'b00100, 3'd2, 1, 0, 0);
    pulses(8);
    chk("resume_8", 5'b00100, 3'd2, 1, 0, 0);
    edge1();
    chk("resume_9", 5'b01000, 3'd3, 1, 0, 1);
    repeat (7) tick();

    pulses(15);
    CP    = 1'b1;
    START = 1'b1;
    tick();
    CP    = 1'b0;
    START = 1'b0;
    chk("start_tc", 5'b00001, 3'd0, 1, 0, 0);
    repeat (7) tick();
    pulses(15);
    chk("restart_15", 5'b00001, 3'd0, 1, 0, 0);
    edge1();
    chk("restart_16", 5'b00010, 3'd1, 1, 0, 1);
    repeat (7) tick();

    CP = 1'b1;
    repeat (50) tick();
    CP = 1'b0;
    repeat (7) tick();
    pulses(14);
    chk("held_15", 5'b00010, 3'd1, 1, 0, 0);
    edge1();
    chk("held_16", 5'b00100, 3'd2, 1, 0, 1);
    repeat (7) tick();

    pulses(15);
    edge1();
    chk("to_lvl3", 5'b01000, 3'd3, 1, 0, 1);
    repeat (7) tick();
    pulses(15);
    edge1();
    chk("to_lvl4", 5'b10000, 3'd4, 1, 0, 1);
    repeat (7) tick();
    pulses(15);
    chk("lvl4_15", 5'b10000, 3'd4, 1, 0, 0);
    edge1();
    chk("finish", 5'b00000, 3'd4, 0, 1, 0);
    tick();
    tests++;
    if (DONE !== 1'b1 || SW !== 5'b00000) begin
      fails++;
      $display("FAIL finish_direct: got done=%b sw=%b, want done=1 sw=00000",
               DONE, SW);
    end
    chk("finish_hold", 5'b00000, 3'd4, 0, 1, 0);

    start();
    chk("fin_restart", 5'b00001, 3'd0, 1, 0, 0);
    pulses(3);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    tests++;
    if ({SW, LEVEL, BUSY, DONE} !== 10'b0) begin
      fails++;
      $display("FAIL rst_direct: got sw=%b lvl=%0d busy=%b done=%b, want all 0",
               SW, LEVEL, BUSY, DONE);
    end
    chk("async_rst", 5'b00000, 3'd0, 0, 0, 0);
    RST = 1'b0;
    pulses(20);
    chk("idle_ignore", 5'b00000, 3'd0, 0, 0, 0);
    start();
    pulses(15);
    chk("post_rst_15", 5'b00001, 3'd0, 1, 0, 0);
    edge1();
    chk("post_rst_16", 5'b00010, 3'd1, 1, 0, 1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
